// File: rtl/arb_pkg.sv
// Shared types and header field layout for the channel block arbiter.
package arb_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned REMW = 9;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_WAIT = 4'b0010,
        ST_HDR  = 4'b0100,
        ST_BODY = 4'b1000
    } state_e;

    localparam int unsigned SIG_HI = 15;
    localparam int unsigned SIG_LO = 14;
    localparam int unsigned LEN_HI = 7;
    localparam int unsigned LEN_LO = 0;

    localparam logic [1:0] SIG_SELF   = 2'b10;
    localparam logic [1:0] SIG_MASTER = 2'b11;

    typedef struct packed {
        logic [1:0] sig;
        logic [5:0] rsvd;
        logic [7:0] len;
    } hdr_t;

    // Words still to read after the header: L for self blocks, L+1 for master blocks.
    function automatic logic [REMW-1:0] hdr_remain(input hdr_t hdr);
        if (hdr.sig == SIG_MASTER) begin
            hdr_remain = REMW'(hdr.len) + REMW'(1);
        end else begin
            hdr_remain = REMW'(hdr.len);
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first requester strictly after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NCH = 16,
    parameter int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [IW-1:0]  grant_c,
    output logic           any_c
);

    logic [31:0] idx;

    always_comb begin
        grant_c = '0;
        any_c   = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = 32'(ptr) + 32'(i);
            if (idx >= 32'(NCH)) begin
                idx = idx - 32'(NCH);
            end
            if (!any_c && req[idx[IW-1:0]]) begin
                any_c   = 1'b1;
                grant_c = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/chan_arbiter.sv
// Drains one whole block at a time from round-robin selected channel FIFOs
// onto a single 16-bit stream, with framing check and stall timeout.
module chan_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NCH     = 16,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    input  logic [16*NCH-1:0] din,
    output logic [NCH-1:0]    ack,
    output logic [15:0]       dout,
    output logic              dvalid,
    output logic              dlast,
    input  logic              dfull,
    output logic [15:0]       errcnt
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned WW = $clog2(RD_LAT + 1);
    localparam int unsigned SW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic [REMW-1:0] remain_q, remain_d;
    logic [NCH-1:0]  ack_q, ack_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            dvalid_q, dvalid_d;
    logic            dlast_q, dlast_d;
    logic [15:0]     errcnt_q, errcnt_d;

    logic [IW-1:0]   pick_c;
    logic            any_c;
    logic [DW-1:0]   word_c;
    hdr_t            hdr_c;
    logic            req_g_c;
    logic            can_sample_c;
    logic            err_inc_c;

    rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .grant_c (pick_c),
        .any_c   (any_c)
    );

    // Granted channel's word and request.
    always_comb begin
        word_c = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (grant_q == IW'(k)) begin
                word_c = din[k*DW +: DW];
            end
        end
        hdr_c        = hdr_t'(word_c);
        req_g_c      = req[grant_q];
        can_sample_c = req_g_c && !dfull && (wait_q == '0);
    end

    // Wait counter holds RD_LAT-1 after a sample so consecutive samples land RD_LAT apart.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        wait_d    = (wait_q != '0) ? wait_q - WW'(1) : wait_q;
        stall_d   = stall_q;
        remain_d  = remain_q;
        ack_d     = '0;
        dout_d    = dout_q;
        dvalid_d  = 1'b0;
        dlast_d   = 1'b0;
        err_inc_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    grant_d = pick_c;
                    wait_d  = WW'(RD_LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req_g_c) begin
                    state_d = ST_IDLE;
                end else if (wait_q <= WW'(1)) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                // A request that vanishes before the header is consumed is simply released.
                if (!req_g_c) begin
                    state_d = ST_IDLE;
                end else if (can_sample_c) begin
                    ack_d[grant_q] = 1'b1;
                    wait_d         = WW'(RD_LAT - 1);
                    stall_d        = '0;
                    if (!hdr_c.sig[1]) begin
                        err_inc_c = 1'b1;
                        ptr_d     = grant_q;
                        state_d   = ST_IDLE;
                    end else begin
                        dout_d   = word_c;
                        dvalid_d = 1'b1;
                        remain_d = hdr_remain(hdr_c);
                        if (hdr_remain(hdr_c) == '0) begin
                            dlast_d = 1'b1;
                            ptr_d   = grant_q;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_BODY;
                        end
                    end
                end
            end
            ST_BODY: begin
                if (can_sample_c) begin
                    ack_d[grant_q] = 1'b1;
                    wait_d         = WW'(RD_LAT - 1);
                    stall_d        = '0;
                    dout_d         = word_c;
                    dvalid_d       = 1'b1;
                    remain_d       = remain_q - REMW'(1);
                    if (remain_q == REMW'(1)) begin
                        dlast_d = 1'b1;
                        ptr_d   = grant_q;
                        state_d = ST_IDLE;
                    end
                end else if (!req_g_c || dfull) begin
                    stall_d = stall_q + SW'(1);
                    if (stall_d == SW'(TIMEOUT)) begin
                        err_inc_c = 1'b1;
                        ptr_d     = grant_q;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        errcnt_d = (err_inc_c && (errcnt_q != 16'hFFFF)) ? errcnt_q + 16'd1 : errcnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            ptr_q    <= IW'(NCH - 1);
            wait_q   <= '0;
            stall_q  <= '0;
            remain_q <= '0;
            ack_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            wait_q   <= wait_d;
            stall_q  <= stall_d;
            remain_q <= remain_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            dlast_q  <= dlast_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign ack    = ack_q;
    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign dlast  = dlast_q;
    assign errcnt = errcnt_q;

endmodule

// File: tb/tb_chan_arbiter.sv
// Directed bench for chan_arbiter: per-channel block memories feed the DUT,
// the output stream is captured and compared against hand-built expectations.
module tb_chan_arbiter;

    localparam int unsigned NCH     = 16;
    localparam int unsigned RD_LAT  = 2;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    req;
    logic [16*NCH-1:0] din;
    logic [NCH-1:0]    ack;
    logic [15:0]       dout;
    logic              dvalid;
    logic              dlast;
    logic              dfull;
    logic [15:0]       errcnt;

    logic [15:0] mem [NCH][64];
    logic [6:0]  len [NCH];
    logic [5:0]  rd  [NCH] = '{default: '0};

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] cap   [$];
    logic [16:0] exp_q [$];
    int cmp_idx = 0;

    int cyc        = 0;
    int ack_total  = 0;
    int onehot_err = 0;
    int ack_cnt  [NCH] = '{default: 0};
    int last_ack [NCH] = '{default: -1};
    int min_gap  [NCH] = '{default: 1000};
    int max_gap  [NCH] = '{default: 0};

    always #4 clk = ~clk;

    chan_arbiter #(.NCH(NCH), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .din    (din),
        .ack    (ack),
        .dout   (dout),
        .dvalid (dvalid),
        .dlast  (dlast),
        .dfull  (dfull),
        .errcnt (errcnt)
    );

    // Channel model: pending while words remain, advances one word per ack.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign req[k]          = ({1'b0, rd[k]} < len[k]);
        assign din[16*k +: 16] = mem[k][rd[k]];
    end

    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (ack[k]) rd[k] <= rd[k] + 6'd1;
        end
    end

    always @(negedge clk) begin
        int gap;
        cyc++;
        if (dvalid) cap.push_back({dlast, dout});
        if ($countones(ack) > 1) onehot_err++;
        for (int k = 0; k < NCH; k++) begin
            if (ack[k]) begin
                ack_total++;
                ack_cnt[k]++;
                if (last_ack[k] >= 0) begin
                    gap = cyc - last_ack[k];
                    if (gap < min_gap[k]) min_gap[k] = gap;
                    if (gap > max_gap[k]) max_gap[k] = gap;
                end
                last_ack[k] = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_blk(input int ch, input logic [15:0] hdr, input int n, input logic [15:0] base);
        mem[ch][len[ch][5:0]] = hdr;
        len[ch] = len[ch] + 7'd1;
        for (int i = 1; i <= n; i++) begin
            mem[ch][len[ch][5:0]] = base + 16'(i);
            len[ch] = len[ch] + 7'd1;
        end
    endtask

    task automatic exp_blk(input logic [15:0] hdr, input int n, input logic [15:0] base, input logic last);
        exp_q.push_back({(n == 0) && last, hdr});
        for (int i = 1; i <= n; i++) exp_q.push_back({(i == n) && last, base + 16'(i)});
    endtask

    task automatic wait_cap(input int n, input int budget);
        int b = 0;
        while (cap.size() < n && b < budget) begin
            tick(1);
            b++;
        end
    endtask

    task automatic wait_ack(input int ch, input int n, input int budget);
        int b = 0;
        while (ack_cnt[ch] < n && b < budget) begin
            tick(1);
            b++;
        end
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_count"}, 32'(cap.size()), 32'(exp_q.size()));
        for (; cmp_idx < exp_q.size(); cmp_idx++) begin
            check(tag, (cmp_idx < cap.size()) ? 32'(cap[cmp_idx]) : 32'hDEAD_BEEF, 32'(exp_q[cmp_idx]));
        end
    endtask

    initial begin
        int snap_v;
        int snap_a;
        for (int k = 0; k < NCH; k++) len[k] = '0;
        rst_n = 1'b0;
        dfull = 1'b0;
        tick(3);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_dvalid", 32'(dvalid), 32'h0);
        check("rst_dlast", 32'(dlast), 32'h0);
        check("rst_errcnt", 32'(errcnt), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // Three simultaneous requesters from reset pointer 15: order 1, 5, 15.
        load_blk(1, 16'h8001, 1, 16'h1110);
        load_blk(5, 16'h8002, 2, 16'h5550);
        load_blk(15, 16'hC000, 1, 16'hF00E);
        exp_blk(16'h8001, 1, 16'h1110, 1'b1);
        exp_blk(16'h8002, 2, 16'h5550, 1'b1);
        exp_blk(16'hC000, 1, 16'hF00E, 1'b1);
        wait_cap(exp_q.size(), 300);
        tick(4);
        cmp_stream("rr_order");

        // Self block, L=5: six words, acks spaced RD_LAT apart.
        load_blk(3, 16'h8305, 5, 16'h3000);
        exp_blk(16'h8305, 5, 16'h3000, 1'b1);
        wait_cap(exp_q.size(), 200);
        tick(4);
        cmp_stream("self_blk");
        check("self_ack_cnt", 32'(ack_cnt[3]), 32'd6);
        check("self_gap_min", 32'(min_gap[3]), 32'(RD_LAT));
        check("self_gap_max", 32'(max_gap[3]), 32'(RD_LAT));

        // Master block: header, trigger, two data words.
        load_blk(0, 16'hC002, 3, 16'h9233);
        exp_blk(16'hC002, 3, 16'h9233, 1'b1);
        wait_cap(exp_q.size(), 200);
        tick(4);
        cmp_stream("master_blk");

        // Backpressure for ten cycles mid-block.
        load_blk(6, 16'h8007, 7, 16'h6000);
        exp_blk(16'h8007, 7, 16'h6000, 1'b1);
        wait_cap(cmp_idx + 3, 200);
        dfull = 1'b1;
        @(negedge clk);
        #1;
        snap_v = cap.size();
        snap_a = ack_total;
        tick(10);
        check("stall_dvalid", 32'(cap.size()), 32'(snap_v));
        check("stall_ack", 32'(ack_total), 32'(snap_a));
        dfull = 1'b0;
        wait_cap(exp_q.size(), 200);
        tick(4);
        cmp_stream("stall_blk");
        check("stall_errcnt", 32'(errcnt), 32'd0);

        // Framing error: header without bit15.
        load_blk(2, 16'h0123, 0, 16'h0000);
        wait_ack(2, 1, 100);
        tick(6);
        check("frame_errcnt", 32'(errcnt), 32'd1);
        check("frame_ack_cnt", 32'(ack_cnt[2]), 32'd1);
        check("frame_no_word", 32'(cap.size()), 32'(exp_q.size()));

        // Channel 4 runs dry after two body words; channel 7 waits behind it.
        load_blk(4, 16'h8005, 2, 16'h4000);
        load_blk(7, 16'h8000, 0, 16'h0000);
        exp_blk(16'h8005, 2, 16'h4000, 1'b0);
        exp_blk(16'h8000, 0, 16'h0000, 1'b1);
        wait_ack(4, 3, 100);
        tick(8);
        check("tmo_not_early", 32'(errcnt), 32'd1);
        check("tmo_no_next_yet", 32'(cap.size()), 32'(exp_q.size() - 1));
        wait_cap(exp_q.size(), 100);
        tick(4);
        check("tmo_errcnt", 32'(errcnt), 32'd2);
        cmp_stream("tmo_blk");

        check("ack_onehot", 32'(onehot_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
